psi_match_scan: RTL and testbench

PSI_MATCH_SCAN -- requirements
Module: psi_match_scan

---
 rtl/psi_match_scan.sv | 138 +++++++++++++
 tb/tb_psi_match_scan.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psi_match_scan.sv
// psi_match_scan
//   Scans a latched, descending-sorted array of K elements (W bits each) for
//   adjacent equal pairs. Each pair found is offered downstream through a
//   valid/ready handshake. A pair is consumed as a unit, so the scan then
//   resumes two positions further on. A one-cycle done pulse ends every scan
//   that runs to completion.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; the results of the last scan are held
//   SCAN  | compares e[idx] with e[idx+1], one pair per cycle
//   EMIT  | offers out_data with out_valid=1 until out_ready is seen
//   DONE  | one-cycle done pulse, then returns to IDLE
//
// Ports
//   clk          clock; every register updates on its rising edge
//   rst          synchronous, active-high reset
//   start        load request; only sampled in IDLE
//   in_array     element i at bits [W*(K-i)-1 : W*(K-i-1)]
//   busy         high in every state except IDLE
//   out_valid    a matched element is on out_data (EMIT only)
//   out_ready    downstream accepts out_data
//   out_data     matched element value; holds its last value outside EMIT
//   done         one-cycle end-of-scan pulse
//   match_count  number of matches emitted in the current or last scan

module psi_match_scan #(
    parameter int W = 3,
    parameter int K = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [W*K-1:0]         in_array,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   done,
    output logic [$clog2(K)-1:0]   match_count
);

    localparam int CW = $clog2(K);
    // One bit more than an element index, so that idx+2 cannot wrap.
    localparam int IW = $clog2(K) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [W*K-1:0] arr_q, arr_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic [W-1:0]   data_q, data_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    logic [W*K-1:0] arr_sh;
    logic [W-1:0]   e_cur, e_nxt;
    logic [IW-1:0]  idx_p1, idx_p2;

    // Element 0 is the top field. Shifting left by idx elements brings e[idx]
    // and e[idx+1] to the two top fields, so no variable part-select is needed.
    assign arr_sh = arr_q << (W * idx);
    assign e_cur  = arr_sh[W*K-1 -: W];
    assign e_nxt  = arr_sh[W*K-W-1 -: W];
    assign idx_p1 = idx + IW'(1);
    assign idx_p2 = idx + IW'(2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            arr_q  <= '0;
            idx    <= '0;
            data_q <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            arr_q  <= arr_nxt;
            idx    <= idx_nxt;
            data_q <= data_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arr_nxt   = arr_q;
        idx_nxt   = idx;
        data_nxt  = data_q;
        cnt_nxt   = cnt;
        busy      = 1'b1;
        out_valid = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    arr_nxt   = in_array;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (e_cur == e_nxt) begin
                    data_nxt  = e_cur;
                    state_nxt = EMIT;
                end else begin
                    idx_nxt   = idx_p1;
                    state_nxt = (idx_p1 >= IW'(K-1)) ? DONE : SCAN;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_nxt   = cnt + CW'(1);
                    idx_nxt   = idx_p2;
                    state_nxt = (idx_p2 >= IW'(K-1)) ? DONE : SCAN;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_data    = data_q;
    assign match_count = cnt;

endmodule

// File: tb/tb_psi_match_scan.sv
// tb_psi_match_scan
//   Drives psi_match_scan with directed and randomized sorted arrays and
//   compares what it emits against a pair-walk reference model.

module tb_psi_match_scan;

    localparam int W  = 3;
    localparam int K  = 8;
    localparam int CW = 3;
    localparam int MAX_EDGES = 400;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W*K-1:0] in_array;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           done;
    logic [CW-1:0]  match_count;

    psi_match_scan #(.W(W), .K(K)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_array    (in_array),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observations collected by run_scan
    logic [W-1:0]  obs_q[$];
    int            obs_done_edge;
    int            obs_done_pulses;
    int            obs_unstable;
    int            obs_valid_cycles;
    int            obs_illegal;
    logic          obs_timeout;
    logic          obs_busy_after;
    logic [CW-1:0] obs_count;

    // Reference model results
    logic [W-1:0]  exp_q[$];
    int            exp_done_edge;

    function automatic logic [W-1:0] elem(input logic [W*K-1:0] a, input int i);
        return a[W*(K-i)-1 -: W];
    endfunction

    function automatic logic [W*K-1:0] pack8(input int v0, v1, v2, v3, v4, v5, v6, v7);
        return {W'(v0), W'(v1), W'(v2), W'(v3), W'(v4), W'(v5), W'(v6), W'(v7)};
    endfunction

    // Walk the array pairwise: an equal pair is emitted and both elements are
    // consumed; otherwise step by one. Edge cost after the start edge: one per
    // unequal compare, and per match one compare + (stall+1) cycles in EMIT.
    task automatic model(input logic [W*K-1:0] a, input int stall);
        int i;
        exp_q.delete();
        exp_done_edge = 0;
        i = 0;
        while (i < K-1) begin
            if (elem(a, i) == elem(a, i+1)) begin
                exp_q.push_back(elem(a, i));
                exp_done_edge += 2 + stall;
                i += 2;
            end else begin
                exp_done_edge += 1;
                i += 1;
            end
        end
    endtask

    // Starts a scan of arr and observes it until the cycle after done.
    // out_ready is held low for 'stall' cycles of each EMIT. With inject=1 a
    // second start carrying arr2 is pulsed while the scan is running.
    task automatic run_scan(input logic [W*K-1:0] arr, input int stall,
                            input logic inject, input logic [W*K-1:0] arr2);
        int n, stall_ctr;
        logic prev_valid, prev_xfer, finished;
        logic [W-1:0] prev_data;
        obs_q.delete();
        obs_done_edge = -1; obs_done_pulses = 0; obs_unstable = 0;
        obs_valid_cycles = 0; obs_illegal = 0; obs_timeout = 1'b0;
        obs_busy_after = 1'b1; obs_count = '0;
        in_array  = arr;
        start     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start    = 1'b0;
        in_array = ~arr;
        n = 0; stall_ctr = 0; prev_valid = 1'b0; prev_xfer = 1'b0;
        prev_data = '0; finished = 1'b0;
        while (!finished && n < MAX_EDGES) begin
            if (inject && n == 2) begin
                start    = 1'b1;
                in_array = arr2;
            end else begin
                start = 1'b0;
            end
            if (out_valid) begin
                obs_valid_cycles++;
                if (prev_valid && !prev_xfer && out_data !== prev_data) obs_unstable++;
                out_ready = (stall_ctr >= stall);
                if (out_ready) begin
                    obs_q.push_back(out_data);
                    stall_ctr = 0;
                end else begin
                    stall_ctr++;
                end
                if (!busy || done) obs_illegal++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_xfer  = out_valid && out_ready;
            if (done) begin
                if (obs_done_pulses == 0) begin
                    obs_done_edge = n;
                    obs_count     = match_count;
                end
                obs_done_pulses++;
            end else if (obs_done_pulses > 0) begin
                obs_busy_after = busy;
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (!finished) obs_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; out_ready = 1'b0;
        in_array = pack8(7, 7, 7, 7, 7, 7, 7, 7);
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%0d want=0", out_data); end
        total++; if (match_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", match_count); end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_priority busy got=%b want=0", busy); end
    endtask

    task automatic test_two_matches();
        run_scan(pack8(7, 6, 5, 5, 3, 2, 2, 0), 0, 1'b0, '0);
        total++; if (obs_timeout) begin bad++; $display("FAIL two_timeout got=no_done want=done"); end
        total++;
        if (obs_q.size() != 2 || obs_q[0] !== 3'd5 || obs_q[1] !== 3'd2) begin
            bad++; $display("FAIL two_emits got=%p want=5,2", obs_q);
        end
        total++; if (obs_count !== 3'd2) begin bad++; $display("FAIL two_count got=%0d want=2", obs_count); end
        total++; if (obs_done_edge != 7) begin bad++; $display("FAIL two_done_cycle got=%0d want=7", obs_done_edge); end
        total++; if (obs_done_pulses != 1) begin bad++; $display("FAIL two_done_width got=%0d want=1", obs_done_pulses); end
        total++; if (obs_busy_after !== 1'b0) begin bad++; $display("FAIL two_idle_after got=%b want=0", obs_busy_after); end
    endtask

    task automatic test_all_distinct();
        run_scan(pack8(7, 6, 5, 4, 3, 2, 1, 0), 0, 1'b0, '0);
        total++; if (obs_valid_cycles != 0) begin bad++; $display("FAIL distinct_valid got=%0d want=0", obs_valid_cycles); end
        total++; if (obs_done_edge != 7) begin bad++; $display("FAIL distinct_done_cycle got=%0d want=7", obs_done_edge); end
        total++; if (obs_count !== 3'd0) begin bad++; $display("FAIL distinct_count got=%0d want=0", obs_count); end
        total++; if (out_data !== 3'd2) begin bad++; $display("FAIL distinct_data_hold got=%0d want=2", out_data); end
    endtask

    task automatic test_pairs_backpressure();
        run_scan(pack8(7, 7, 5, 5, 3, 3, 1, 1), 3, 1'b0, '0);
        total++;
        if (obs_q.size() != 4 || obs_q[0] !== 3'd7 || obs_q[1] !== 3'd5 ||
            obs_q[2] !== 3'd3 || obs_q[3] !== 3'd1) begin
            bad++; $display("FAIL pairs_emits got=%p want=7,5,3,1", obs_q);
        end
        total++; if (obs_unstable != 0) begin bad++; $display("FAIL pairs_stable got=%0d want=0", obs_unstable); end
        total++; if (obs_count !== 3'd4) begin bad++; $display("FAIL pairs_count got=%0d want=4", obs_count); end
        total++; if (obs_valid_cycles != 16) begin bad++; $display("FAIL pairs_valid_cycles got=%0d want=16", obs_valid_cycles); end
        total++; if (obs_done_edge != 20) begin bad++; $display("FAIL pairs_done_cycle got=%0d want=20", obs_done_edge); end
        @(posedge clk); #1;
        total++; if (match_count !== 3'd4) begin bad++; $display("FAIL pairs_count_hold got=%0d want=4", match_count); end
    endtask

    task automatic test_start_during_busy();
        run_scan(pack8(7, 6, 5, 5, 3, 2, 2, 0), 0, 1'b1, pack8(7, 7, 7, 7, 7, 7, 7, 7));
        total++;
        if (obs_q.size() != 2 || obs_q[0] !== 3'd5 || obs_q[1] !== 3'd2) begin
            bad++; $display("FAIL busy_start_emits got=%p want=5,2", obs_q);
        end
        total++; if (obs_count !== 3'd2) begin bad++; $display("FAIL busy_start_count got=%0d want=2", obs_count); end
        total++; if (obs_done_edge != 7) begin bad++; $display("FAIL busy_start_done_cycle got=%0d want=7", obs_done_edge); end
    endtask

    task automatic test_reset_mid_emit();
        int emits, guard, dones;
        logic [W*K-1:0] arr;
        arr = pack8(7, 7, 5, 5, 3, 2, 1, 0);
        in_array = arr; start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        emits = 0; guard = 0;
        // Accept the first emit, then stall on the second and reset there.
        while (guard < 50 && !(out_valid && emits == 1)) begin
            if (out_valid) begin
                out_ready = 1'b1;
                emits = 1;
            end else begin
                out_ready = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        total++; if (guard >= 50) begin bad++; $display("FAIL rst_emit_timeout got=no_second_emit want=second_emit"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({busy, out_valid, done} !== 3'b000 || out_data !== '0 || match_count !== '0) begin
            bad++;
            $display("FAIL rst_emit_outputs got=busy%b valid%b done%b data%0d cnt%0d want=all_zero",
                     busy, out_valid, done, out_data, match_count);
        end
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) dones++;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL rst_emit_no_done got=%0d want=0", dones); end
        model(arr, 1);
        run_scan(arr, 1, 1'b0, '0);
        total++; if (obs_q != exp_q) begin bad++; $display("FAIL rst_emit_restart_emits got=%p want=%p", obs_q, exp_q); end
        total++; if (obs_done_edge != exp_done_edge) begin bad++; $display("FAIL rst_emit_restart_done got=%0d want=%0d", obs_done_edge, exp_done_edge); end
        total++; if (obs_count !== CW'(exp_q.size())) begin bad++; $display("FAIL rst_emit_restart_count got=%0d want=%0d", obs_count, exp_q.size()); end
    endtask

    task automatic test_random();
        logic [W*K-1:0] arr;
        int v, stall;
        for (int it = 0; it < 25; it++) begin
            v = $urandom_range(0, 7);
            arr = '0;
            for (int i = 0; i < K; i++) begin
                arr[W*(K-i)-1 -: W] = W'(v);
                v = v - int'($urandom_range(0, 2));
                if (v < 0) v = 0;
            end
            stall = $urandom_range(0, 2);
            model(arr, stall);
            run_scan(arr, stall, 1'($urandom_range(0, 1)), W*K'($urandom));
            total++; if (obs_timeout) begin bad++; $display("FAIL rand_timeout it=%0d got=no_done want=done", it); end
            total++; if (obs_q != exp_q) begin bad++; $display("FAIL rand_emits it=%0d arr=%h got=%p want=%p", it, arr, obs_q, exp_q); end
            total++; if (obs_count !== CW'(exp_q.size())) begin bad++; $display("FAIL rand_count it=%0d got=%0d want=%0d", it, obs_count, exp_q.size()); end
            total++; if (obs_done_edge != exp_done_edge) begin bad++; $display("FAIL rand_done_cycle it=%0d got=%0d want=%0d", it, obs_done_edge, exp_done_edge); end
            total++; if (obs_unstable != 0 || obs_illegal != 0 || obs_done_pulses != 1) begin
                bad++; $display("FAIL rand_protocol it=%0d unstable=%0d illegal=%0d done_pulses=%0d want=0,0,1",
                                it, obs_unstable, obs_illegal, obs_done_pulses);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; in_array = '0;
        test_reset();
        test_two_matches();
        test_all_distinct();
        test_pairs_backpressure();
        test_start_during_busy();
        test_reset_mid_emit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
